// File: rtl/mcht_tx_enc.sv
// Manchester line transmitter: sync cell, LSB-first data cells, then an idle guard.
// TXD is registered from the next-state line value so edges line up with state changes.
module mcht_tx_enc #(
  parameter int unsigned pMSG_LEN  = 8,
  parameter int unsigned pHALF_CYC = 4,
  parameter int unsigned pIDLE_CYC = 16
) (
  input  logic                CLK125M,
  input  logic                RST_N,
  input  logic [pMSG_LEN-1:0] MSG_IN,
  input  logic                MSG_VLD,
  output logic                MSG_RDY,
  output logic                TXD,
  output logic                TX_BUSY
);

  localparam int unsigned HW = $clog2(pHALF_CYC);
  localparam int unsigned BW = $clog2(pMSG_LEN);
  localparam int unsigned GW = $clog2(pIDLE_CYC + 1);

  localparam logic [HW-1:0] H_LAST = HW'(pHALF_CYC - 1);
  localparam logic [BW-1:0] B_LAST = BW'(pMSG_LEN - 1);
  localparam logic [GW-1:0] G_LAST = GW'(pIDLE_CYC - 1);

  typedef enum logic [2:0] {
    GUARD,
    IDLE,
    SYNC_LO,
    SYNC_HI,
    BIT_H1,
    BIT_H2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [HW-1:0]       hcnt;
  logic [BW-1:0]       bidx;
  logic [GW-1:0]       gcnt;
  logic [pMSG_LEN-1:0] shreg;
  logic [pMSG_LEN-1:0] shreg_nxt;
  logic                half_done;
  logic                txd_nxt;

  // State register, counters, shift register and the TXD flop
  always_ff @(posedge CLK125M or negedge RST_N) begin
    if (!RST_N) begin
      state <= GUARD;
      hcnt  <= '0;
      bidx  <= '0;
      gcnt  <= '0;
      shreg <= '0;
      TXD   <= 1'b1;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      TXD   <= txd_nxt;

      if (state_nxt != state || state == IDLE || state == GUARD)
        hcnt <= '0;
      else
        hcnt <= hcnt + 1'b1;

      if (state == GUARD && state_nxt == GUARD)
        gcnt <= gcnt + 1'b1;
      else
        gcnt <= '0;

      if (state == IDLE)
        bidx <= '0;
      else if (state == BIT_H2 && half_done)
        bidx <= (bidx == B_LAST) ? '0 : bidx + 1'b1;
    end
  end

  // Next-state and shift-register update
  always_comb begin
    half_done = (hcnt == H_LAST);
    state_nxt = state;
    shreg_nxt = shreg;
    case (state)
      GUARD:   if (gcnt == G_LAST) state_nxt = IDLE;
      IDLE: begin
        if (MSG_VLD) begin
          state_nxt = SYNC_LO;
          shreg_nxt = MSG_IN;
        end
      end
      SYNC_LO: if (half_done) state_nxt = SYNC_HI;
      SYNC_HI: if (half_done) state_nxt = BIT_H1;
      BIT_H1:  if (half_done) state_nxt = BIT_H2;
      BIT_H2: begin
        if (half_done) begin
          shreg_nxt = {1'b0, shreg[pMSG_LEN-1:1]};
          state_nxt = (bidx == B_LAST) ? GUARD : BIT_H1;
        end
      end
      default: state_nxt = GUARD;
    endcase
  end

  // Line value follows the next state; status outputs follow the current state
  always_comb begin
    case (state_nxt)
      SYNC_LO: txd_nxt = 1'b0;
      BIT_H1:  txd_nxt = ~shreg_nxt[0];
      BIT_H2:  txd_nxt = shreg_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
    MSG_RDY = (state == IDLE);
    TX_BUSY = (state != IDLE);
  end

endmodule
